// File: rtl/conv_window3x3.sv
// conv_window3x3: turns a raster pixel stream into every valid 3x3 window (stride 1, no padding)
module conv_window3x3 #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  localparam int CW = $clog2(IMG_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data_in,
  output logic               win_valid,
  output logic [9*WIDTH-1:0] window,
  output logic [CW-1:0]      win_row,
  output logic [CW-1:0]      win_col,
  output logic               frame_done
);
  logic [CW-1:0] col_cnt, row_cnt;
  logic [WIDTH-1:0] lb0 [IMG_W];
  logic [WIDTH-1:0] lb1 [IMG_W];
  logic [WIDTH-1:0] w [3][3];
  logic [WIDTH-1:0] lb0_out, lb1_out;
  logic col_last, row_last, in_win;
  // Line buffers are addressed by column, so each slot returns the pixel written one and two lines ago
  assign lb0_out  = lb0[col_cnt];
  assign lb1_out  = lb1[col_cnt];
  assign col_last = col_cnt == CW'(IMG_W - 1);
  assign row_last = row_cnt == CW'(IMG_H - 1);
  assign in_win   = row_cnt >= CW'(2) && col_cnt >= CW'(2);
  assign window   = {w[0][0], w[0][1], w[0][2], w[1][0], w[1][1], w[1][2], w[2][0], w[2][1], w[2][2]};
  always_ff @(posedge clk)
    if (in_valid) begin
      lb1[col_cnt] <= data_in;
      lb0[col_cnt] <= lb1_out;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else begin
      win_valid  <= in_valid && in_win;
      frame_done <= in_valid && col_last && row_last;
      if (in_valid) begin
        col_cnt <= col_last ? '0 : col_cnt + 1'b1;
        if (col_last) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= lb0_out;
        w[1][2] <= lb1_out;
        w[2][2] <= data_in;
        if (in_win) begin
          win_row <= row_cnt - CW'(2);
          win_col <= col_cnt - CW'(2);
        end
      end
    end
endmodule
